// File: rtl/data_memory_ctrl.sv
// Single-port data memory controller for an RV32I load/store unit.
// One request in flight: IDLE -> ACC0 [-> ACC1] -> RESP; misaligned accesses split or fault.
module data_memory_ctrl #(
    parameter int DEPTH_WORDS    = 1024,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t          state_q, state_d;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [1:0]      off_q;
    logic [AW-1:0]   widx_q;
    logic [31:0]     wdata_q;
    logic            split_q;
    logic [31:0]     lo_q;
    logic            rsp_valid_q;
    logic [31:0]     rsp_rdata_q;
    logic            rsp_fault_q;
    logic [31:0]     mem_q [DEPTH_WORDS] = '{default: 32'h0};

    logic            accept_s;
    logic            illegal_s;
    logic            misal_s;
    logic            fault_in_s;
    logic [AW-1:0]   widx1_s;
    logic [3:0]      mask_s;
    logic [7:0]      be_s;
    logic [63:0]     wd64_s;
    logic [31:0]     lo_s;
    logic [31:0]     hi_s;
    logic [31:0]     win_s;
    logic [31:0]     load_s;
    logic            unused_s;

    assign unused_s  = ^req_addr[31:AW+2];
    assign req_ready = (state_q == IDLE) & ~rst;
    assign accept_s  = req_valid & req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;

    // Classify the incoming request: illegal size code and misalignment.
    always_comb begin
        illegal_s = 1'b1;
        misal_s   = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
            3'b100, 3'b101:         illegal_s = req_we;
            default:                illegal_s = 1'b1;
        endcase
        case (req_funct3[1:0])
            2'b01:   misal_s = req_addr[0];
            2'b10:   misal_s = (req_addr[1:0] != 2'b00);
            default: misal_s = 1'b0;
        endcase
        fault_in_s = illegal_s | (misal_s & (MISALIGN_SPLIT == 0));
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = fault_in_s ? RESP : ACC0;
                end else begin
                    state_d = IDLE;
                end
            end
            ACC0:    state_d = split_q ? ACC1 : RESP;
            ACC1:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Byte lanes span two words: be_s[3:0] for word w, be_s[7:4] for word w+1.
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   mask_s = 4'b0001;
            2'b01:   mask_s = 4'b0011;
            default: mask_s = 4'b1111;
        endcase
        widx1_s = widx_q + {{(AW-1){1'b0}}, 1'b1};
        be_s    = {4'b0000, mask_s} << off_q;
        wd64_s  = {32'h0, wdata_q} << {off_q, 3'b000};
        lo_s    = (state_q == ACC0) ? mem_q[widx_q] : lo_q;
        hi_s    = mem_q[widx1_s];
        win_s   = 32'({hi_s, lo_s} >> {off_q, 3'b000});
    end

    // Load extension by size code.
    always_comb begin
        load_s = win_s;
        case (funct3_q)
            3'b000:  load_s = {{24{win_s[7]}}, win_s[7:0]};
            3'b100:  load_s = {24'h0, win_s[7:0]};
            3'b001:  load_s = {{16{win_s[15]}}, win_s[15:0]};
            3'b101:  load_s = {16'h0, win_s[15:0]};
            default: load_s = win_s;
        endcase
    end

    // State register and request capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            off_q    <= 2'b00;
            widx_q   <= '0;
            wdata_q  <= 32'h0;
            split_q  <= 1'b0;
            lo_q     <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept_s) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                off_q    <= req_addr[1:0];
                widx_q   <= req_addr[AW+1:2];
                wdata_q  <= req_wdata;
                split_q  <= misal_s;
            end
            if (state_q == ACC0) begin
                lo_q <= mem_q[widx_q];
            end
        end
    end

    // Array writes; a reset edge suppresses the write of the beat it lands on.
    always_ff @(posedge clk) begin
        if (!rst && we_q) begin
            if (state_q == ACC0) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_s[b]) mem_q[widx_q][8*b +: 8] <= wd64_s[8*b +: 8];
                end
            end else if (state_q == ACC1) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_s[4+b]) mem_q[widx1_s][8*b +: 8] <= wd64_s[32+8*b +: 8];
                end
            end
        end
    end

    // Response registers load on entry to RESP and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_fault_q <= 1'b0;
        end else begin
            rsp_valid_q <= (state_d == RESP);
            if (state_d == RESP) begin
                if (state_q == IDLE) begin
                    rsp_fault_q <= 1'b1;
                    rsp_rdata_q <= 32'h0;
                end else begin
                    rsp_fault_q <= 1'b0;
                    rsp_rdata_q <= we_q ? 32'h0 : load_s;
                end
            end
        end
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: instance a (16 words, split) and instance b (16 words, fault on misalign).
module tb_data_memory_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        sel_b = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;

    logic        valid_a, valid_b, ready_a, ready_b;
    logic        rv_a, rv_b, rf_a, rf_b;
    logic [31:0] rd_a, rd_b;
    logic        cur_ready, cur_rv, cur_rf;
    logic [31:0] cur_rd;

    int n_cmp = 0;
    int n_bad = 0;

    assign valid_a   = req_valid & ~sel_b;
    assign valid_b   = req_valid & sel_b;
    assign cur_ready = sel_b ? ready_b : ready_a;
    assign cur_rv    = sel_b ? rv_b : rv_a;
    assign cur_rf    = sel_b ? rf_b : rf_a;
    assign cur_rd    = sel_b ? rd_b : rd_a;

    always #5 clk = ~clk;

    data_memory_ctrl #(.DEPTH_WORDS(16), .MISALIGN_SPLIT(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(ready_a),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_fault(rf_a)
    );

    data_memory_ctrl #(.DEPTH_WORDS(16), .MISALIGN_SPLIT(0)) dut_b (
        .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(ready_b),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_fault(rf_b)
    );

    // Issue one request on the selected instance; lat = 0 means no response seen.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic flt);
        int waits;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        waits = 0;
        while (!cur_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; rd = 32'h0; flt = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (cur_rv) begin
                lat = i; rd = cur_rd; flt = cur_rf;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat; logic [31:0] rd; logic flt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (ready_a !== 1'b0 || rv_a !== 1'b0 || rd_a !== 32'h0 || rf_a !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: ready=%b valid=%b rdata=%h fault=%b, want 0 0 00000000 0",
                     ready_a, rv_a, rd_a, rf_a);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ready_a !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset: got %b want 1", ready_a);
        end
        do_req(1'b0, 3'b010, 32'h0, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'h0 || lat !== 2) begin
            n_bad++;
            $display("FAIL word0_init: rdata=%h lat=%0d want 00000000 lat 2", rd, lat);
        end
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic flt;
        do_req(1'b1, 3'b010, 32'h10, 32'h11223344, lat, rd, flt);
        n_cmp++;
        if (lat !== 2 || rd !== 32'h0 || flt !== 1'b0) begin
            n_bad++;
            $display("FAIL sw_resp: lat=%0d rdata=%h fault=%b want 2 00000000 0", lat, rd, flt);
        end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, flt);
        n_cmp++;
        if (lat !== 2 || rd !== 32'h11223344 || flt !== 1'b0) begin
            n_bad++;
            $display("FAIL lw_after_sw: lat=%0d rdata=%h fault=%b want 2 11223344 0", lat, rd, flt);
        end
        @(negedge clk);
        n_cmp++;
        if (rv_a !== 1'b0 || rd_a !== 32'h11223344) begin
            n_bad++;
            $display("FAIL rsp_hold: valid=%b rdata=%h want 0 11223344", rv_a, rd_a);
        end
    endtask

    task automatic test_byte();
        int lat; logic [31:0] rd; logic flt;
        do_req(1'b1, 3'b000, 32'h11, 32'h000000AB, lat, rd, flt);
        do_req(1'b0, 3'b000, 32'h11, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'hFFFFFFAB) begin
            n_bad++;
            $display("FAIL lb_sign: got %h want ffffffab", rd);
        end
        do_req(1'b0, 3'b100, 32'h11, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'h000000AB) begin
            n_bad++;
            $display("FAIL lbu_zero: got %h want 000000ab", rd);
        end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'h1122AB44) begin
            n_bad++;
            $display("FAIL lw_after_sb: got %h want 1122ab44", rd);
        end
    endtask

    task automatic test_split();
        int lat; logic [31:0] rd; logic flt;
        do_req(1'b1, 3'b010, 32'h0C, 32'h0, lat, rd, flt);
        do_req(1'b1, 3'b010, 32'h0E, 32'hDEADBEEF, lat, rd, flt);
        n_cmp++;
        if (lat !== 3 || flt !== 1'b0) begin
            n_bad++;
            $display("FAIL split_sw_lat: lat=%0d fault=%b want 3 0", lat, flt);
        end
        do_req(1'b0, 3'b010, 32'h0E, 32'h0, lat, rd, flt);
        n_cmp++;
        if (lat !== 3 || rd !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL split_lw: lat=%0d rdata=%h want 3 deadbeef", lat, rd);
        end
        do_req(1'b0, 3'b010, 32'h0C, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'hBEEF0000) begin
            n_bad++;
            $display("FAIL split_word3: got %h want beef0000", rd);
        end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'h1122DEAD) begin
            n_bad++;
            $display("FAIL split_word4: got %h want 1122dead", rd);
        end
        do_req(1'b0, 3'b001, 32'h0F, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'hFFFFADBE || lat !== 3) begin
            n_bad++;
            $display("FAIL split_lh: rdata=%h lat=%0d want ffffadbe 3", rd, lat);
        end
        do_req(1'b0, 3'b101, 32'h0F, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'h0000ADBE) begin
            n_bad++;
            $display("FAIL split_lhu: got %h want 0000adbe", rd);
        end
    endtask

    task automatic test_fault();
        int lat; logic [31:0] rd; logic flt;
        sel_b = 1'b1;
        do_req(1'b1, 3'b010, 32'h00, 32'h12345678, lat, rd, flt);
        do_req(1'b0, 3'b010, 32'h00, 32'h0, lat, rd, flt);
        do_req(1'b0, 3'b001, 32'h01, 32'h0, lat, rd, flt);
        n_cmp++;
        if (flt !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
            n_bad++;
            $display("FAIL nosplit_lh_fault: fault=%b rdata=%h lat=%0d want 1 00000000 1", flt, rd, lat);
        end
        do_req(1'b1, 3'b001, 32'h01, 32'h0000FFFF, lat, rd, flt);
        n_cmp++;
        if (flt !== 1'b1 || lat !== 1) begin
            n_bad++;
            $display("FAIL nosplit_sh_fault: fault=%b lat=%0d want 1 1", flt, lat);
        end
        do_req(1'b0, 3'b010, 32'h00, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'h12345678 || flt !== 1'b0) begin
            n_bad++;
            $display("FAIL nosplit_mem_unchanged: rdata=%h fault=%b want 12345678 0", rd, flt);
        end
        sel_b = 1'b0;
        do_req(1'b0, 3'b011, 32'h10, 32'h0, lat, rd, flt);
        n_cmp++;
        if (flt !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
            n_bad++;
            $display("FAIL funct3_011_fault: fault=%b rdata=%h lat=%0d want 1 00000000 1", flt, rd, lat);
        end
        do_req(1'b1, 3'b100, 32'h10, 32'h55, lat, rd, flt);
        n_cmp++;
        if (flt !== 1'b1 || lat !== 1) begin
            n_bad++;
            $display("FAIL store_bu_fault: fault=%b lat=%0d want 1 1", flt, lat);
        end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'h1122DEAD) begin
            n_bad++;
            $display("FAIL fault_no_write: got %h want 1122dead", rd);
        end
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] rd; logic flt;
        do_req(1'b1, 3'b010, 32'h3C, 32'h0, lat, rd, flt);
        do_req(1'b1, 3'b010, 32'h3E, 32'hCAFEF00D, lat, rd, flt);
        do_req(1'b0, 3'b010, 32'h3C, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'hF00D0000) begin
            n_bad++;
            $display("FAIL wrap_last_word: got %h want f00d0000", rd);
        end
        do_req(1'b0, 3'b010, 32'h00, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'h0000CAFE) begin
            n_bad++;
            $display("FAIL wrap_word0: got %h want 0000cafe", rd);
        end
        do_req(1'b0, 3'b010, 32'h40, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'h0000CAFE || flt !== 1'b0) begin
            n_bad++;
            $display("FAIL alias_0x40: rdata=%h fault=%b want 0000cafe 0", rd, flt);
        end
        do_req(1'b0, 3'b010, 32'h3E, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'hCAFEF00D || lat !== 3) begin
            n_bad++;
            $display("FAIL wrap_split_lw: rdata=%h lat=%0d want cafef00d 3", rd, lat);
        end
    endtask

    task automatic test_abort();
        int lat; logic [31:0] rd; logic flt;
        int seen;
        do_req(1'b1, 3'b010, 32'h1C, 32'h11111111, lat, rd, flt);
        do_req(1'b1, 3'b010, 32'h20, 32'h22222222, lat, rd, flt);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h1E; req_wdata = 32'h55667788;
        n_cmp++;
        if (ready_a !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_ready_before: got %b want 1", ready_a);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        seen = 0;
        @(negedge clk);
        if (rv_a) seen++;
        n_cmp++;
        if (ready_a !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_in_reset: got %b want 0", ready_a);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        if (rv_a) seen++;
        n_cmp++;
        if (ready_a !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_abort: got %b want 1", ready_a);
        end
        repeat (3) begin
            @(negedge clk);
            if (rv_a) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL abort_no_rsp: rsp_valid seen %0d times want 0", seen);
        end
        do_req(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'h22222222) begin
            n_bad++;
            $display("FAIL abort_w1_unchanged: got %h want 22222222", rd);
        end
        do_req(1'b0, 3'b010, 32'h1C, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'h77881111) begin
            n_bad++;
            $display("FAIL abort_acc0_kept: got %h want 77881111", rd);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic flt;
        do_req(1'b1, 3'b001, 32'h22, 32'h00008001, lat, rd, flt);
        do_req(1'b0, 3'b001, 32'h22, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'hFFFF8001 || lat !== 2) begin
            n_bad++;
            $display("FAIL b2b_lh: rdata=%h lat=%0d want ffff8001 2", rd, lat);
        end
        do_req(1'b0, 3'b101, 32'h22, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'h00008001) begin
            n_bad++;
            $display("FAIL b2b_lhu: got %h want 00008001", rd);
        end
        do_req(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'h80012222) begin
            n_bad++;
            $display("FAIL b2b_lw: got %h want 80012222", rd);
        end
        do_req(1'b0, 3'b000, 32'h23, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'hFFFFFF80) begin
            n_bad++;
            $display("FAIL b2b_lb_hi: got %h want ffffff80", rd);
        end
        do_req(1'b0, 3'b000, 32'h22, 32'h0, lat, rd, flt);
        n_cmp++;
        if (rd !== 32'h00000001) begin
            n_bad++;
            $display("FAIL b2b_lb_lo: got %h want 00000001", rd);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_split();
        test_fault();
        test_wrap();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
